// File: rtl/ram_program_loader.sv
// Program-image loader: streams bytes into consecutive RAM addresses, optionally reads each
// location back against a shadow copy, and holds the CPU off the bus while doing so.
module ram_program_loader #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter bit          VERIFY = 1'b1
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              byte_valid,
   input  logic [DATA_W-1:0] byte_in,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] address,
   output logic              R_W,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic [DATA_W-1:0] data_in,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] error_addr
);

   localparam int unsigned     Depth   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] CntFull = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      StIdle, StWaitByte, StWrite, StVaddr, StVcmp, StDone, StError
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] eaddr_q, eaddr_d;
   logic              shadow_we;
   logic [DATA_W-1:0] shadow [Depth];

   // State register.
   always_ff @(posedge CLK) begin
      if (CLR) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Datapath registers: pointer, counter, captured base/length, write byte, error address.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         ptr_q   <= '0;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         eaddr_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         eaddr_q <= eaddr_d;
      end
   end

   // Shadow copy of every accepted byte; deliberately not cleared by reset.
   always_ff @(posedge CLK) begin
      if (shadow_we) shadow[ptr_q] <= byte_in;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      base_d    = base_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      eaddr_d   = eaddr_q;
      shadow_we = 1'b0;
      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               base_d  = base_addr;
               ptr_d   = base_addr;
               len_d   = (length == '0) ? CntFull : length;
               cnt_d   = (length == '0) ? CntFull : length;
               eaddr_d = '0;
               state_d = StWaitByte;
            end
         end
         StWaitByte: begin
            if (byte_valid) begin
               data_d    = byte_in;
               shadow_we = 1'b1;
               state_d   = StWrite;
            end
         end
         StWrite: begin
            ptr_d = ptr_q + PtrOne;
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
               if (VERIFY) begin
                  // Rewind for the read-back pass over the same span.
                  ptr_d   = base_q;
                  cnt_d   = len_q;
                  state_d = StVaddr;
               end else begin
                  state_d = StDone;
               end
            end else begin
               state_d = StWaitByte;
            end
         end
         StVaddr: state_d = StVcmp;
         StVcmp: begin
            if (data_in != shadow[ptr_q]) begin
               eaddr_d = ptr_q;
               state_d = StError;
            end else begin
               ptr_d   = ptr_q + PtrOne;
               cnt_d   = cnt_q - CntOne;
               state_d = (cnt_q == CntOne) ? StDone : StVaddr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus and status outputs decoded from state; only WRITE drives the bus.
   always_comb begin
      byte_ready = (state_q == StWaitByte);
      data_oe    = (state_q == StWrite);
      R_W        = (state_q != StWrite);
      address    = ptr_q;
      data_out   = data_q;
      busy       = (state_q == StWaitByte) || (state_q == StWrite) ||
                   (state_q == StVaddr) || (state_q == StVcmp);
      cpu_hold   = busy || (state_q == StError);
      done       = (state_q == StDone);
      error      = (state_q == StError);
      error_addr = eaddr_q;
   end

endmodule

// File: tb/tb_ram_program_loader.sv
// Bench for ram_program_loader: a RAM model on the bus, directed and random loads checked
// against expected writes, final RAM image, status levels and cycle counts.
module tb_ram_program_loader;

   logic       CLK = 1'b0;
   logic       CLR;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] length;
   logic       byte_valid;
   logic [7:0] byte_in;
   logic       byte_ready;
   logic [3:0] address;
   logic       R_W;
   logic [7:0] data_out;
   logic       data_oe;
   logic [7:0] data_in;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] error_addr;

   int tests = 0;
   int fails = 0;
   int viol  = 0;

   logic [7:0]  ram   [16];
   logic [7:0]  bytes [16];
   logic [11:0] wlog  [$];
   logic        fault_en   = 1'b0;
   logic [3:0]  fault_addr = 4'd0;

   ram_program_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY(1'b1)) dut (
      .CLK        (CLK),
      .CLR        (CLR),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .byte_ready (byte_ready),
      .address    (address),
      .R_W        (R_W),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .data_in    (data_in),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .error_addr (error_addr)
   );

   always #5 CLK = ~CLK;

   // RAM read path, with an optional stuck-at-FF fault on one address.
   assign data_in = (fault_en && address == fault_addr) ? 8'hFF : ram[address];

   // Bus monitor: a write is committed at the posedge following a negedge with R_W low.
   always @(negedge CLK) begin
      if (R_W === 1'b0) begin
         wlog.push_back({address, data_out});
         ram[address] = data_out;
      end
      if ((data_oe !== ~R_W) || (byte_ready && data_oe)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One load of n bytes from bytes[] at base; gap=1 offers a byte only every 3rd cycle;
   // extra=1 pulses start with different base/length while busy.
   task automatic do_load(input logic [3:0] base, input int n, input bit gap, input bit extra);
      int          k;
      int          idx;
      bit          hs;
      bit          exp_err;
      logic [3:0]  exp_eaddr;
      logic [3:0]  a;
      exp_err   = 1'b0;
      exp_eaddr = 4'd0;
      if (fault_en) begin
         for (int i = 0; i < n; i++) begin
            a = base + 4'(i);
            if (!exp_err && a == fault_addr && bytes[i] != 8'hFF) begin
               exp_err   = 1'b1;
               exp_eaddr = a;
            end
         end
      end
      wlog.delete();
      @(negedge CLK);
      start      = 1'b1;
      base_addr  = base;
      length     = (n == 16) ? 5'd0 : 5'(n);
      byte_valid = 1'b0;
      @(negedge CLK);
      start = 1'b0;
      check("start_clears_error", {29'd0, error, done, busy}, 32'h1);
      check("start_hold", {31'd0, cpu_hold}, 32'h1);
      k   = 0;
      idx = 0;
      while (!(done || error) && k < 400) begin
         start = 1'b0;
         if (extra && k == 5) begin
            start     = 1'b1;
            base_addr = base + 4'd5;
            length    = 5'd7;
         end
         byte_valid = (idx < n) && (!gap || (k % 3 == 0));
         byte_in    = (idx < n) ? bytes[idx] : 8'h00;
         hs         = byte_valid && byte_ready;
         @(negedge CLK);
         if (hs) idx++;
         k++;
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      check("no_timeout", {31'd0, k < 400}, 32'h1);
      check("done", {31'd0, done}, {31'd0, !exp_err});
      check("error", {31'd0, error}, {31'd0, exp_err});
      check("cpu_hold_end", {31'd0, cpu_hold}, {31'd0, exp_err});
      check("busy_end", {31'd0, busy}, 32'h0);
      if (exp_err) check("error_addr", {28'd0, error_addr}, {28'd0, exp_eaddr});
      if (!gap && !exp_err) check("latency", k, 4 * n);
      check("write_count", wlog.size(), n);
      for (int i = 0; i < n && i < wlog.size(); i++) begin
         a = base + 4'(i);
         check("write_entry", {20'd0, wlog[i]}, {20'd0, a, bytes[i]});
         check("ram_image", {24'd0, ram[a]}, {24'd0, bytes[i]});
      end
   endtask

   initial begin
      CLR        = 1'b1;
      start      = 1'b0;
      base_addr  = 4'd0;
      length     = 5'd0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (3) @(negedge CLK);
      CLR = 1'b0;
      check("rst_R_W", {31'd0, R_W}, 32'h1);
      check("rst_flags", {25'd0, data_oe, byte_ready, cpu_hold, busy, done, error, 1'b0}, 32'h0);
      check("rst_data_out", {24'd0, data_out}, 32'h0);
      check("rst_address", {28'd0, address}, 32'h0);
      check("rst_error_addr", {28'd0, error_addr}, 32'h0);

      // Short load, continuous stream.
      bytes[0] = 8'h2A; bytes[1] = 8'h15; bytes[2] = 8'h80;
      do_load(4'd0, 3, 1'b0, 1'b0);

      // Wrap across the top of memory.
      for (int i = 0; i < 4; i++) bytes[i] = 8'(i + 1);
      do_load(4'd14, 4, 1'b0, 1'b0);

      // Full-depth load (length 0).
      for (int i = 0; i < 16; i++) bytes[i] = 8'(i);
      do_load(4'd0, 16, 1'b0, 1'b0);

      // Read-back fault at address 2, then a clean load clears the error.
      bytes[0] = 8'h2A; bytes[1] = 8'h15; bytes[2] = 8'h80;
      fault_en   = 1'b1;
      fault_addr = 4'd2;
      do_load(4'd0, 3, 1'b0, 1'b0);
      fault_en = 1'b0;
      do_load(4'd0, 3, 1'b0, 1'b0);

      // Reset during the second WRITE.
      @(negedge CLK);
      start      = 1'b1;
      base_addr  = 4'd0;
      length     = 5'd5;
      byte_valid = 1'b1;
      byte_in    = 8'h5A;
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      check("second_write_R_W", {31'd0, R_W}, 32'h0);
      CLR = 1'b1;
      @(negedge CLK);
      CLR        = 1'b0;
      byte_valid = 1'b0;
      check("clr_R_W", {31'd0, R_W}, 32'h1);
      check("clr_flags", {28'd0, data_oe, busy, cpu_hold, done}, 32'h0);
      for (int i = 0; i < 5; i++) bytes[i] = 8'hC0 + 8'(i);
      do_load(4'd3, 5, 1'b0, 1'b0);

      // Sparse stream with a stray start while busy.
      for (int i = 0; i < 6; i++) bytes[i] = 8'h90 + 8'(i);
      do_load(4'd9, 6, 1'b1, 1'b1);

      // Random loads, some with a read-back fault.
      for (int t = 0; t < 8; t++) begin
         int          n;
         logic [3:0]  b;
         bit          g;
         n = $urandom_range(1, 16);
         b = 4'($urandom_range(0, 15));
         g = 1'($urandom_range(0, 1));
         for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom_range(0, 255));
         fault_en   = ($urandom_range(0, 3) == 0);
         fault_addr = 4'($urandom_range(0, 15));
         do_load(b, n, g, 1'($urandom_range(0, 1)));
      end
      fault_en = 1'b0;

      check("bus_protocol", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Bus initiator that writes a program image into the 16x8 RAM before the basic computer runs. It is the writer side of the RAM's Data_Bus/R_W interface, whose reader side is the CPU fetch path (AR drives address, T1 reads).
- Takes bytes over a valid/ready stream and writes them to consecutive addresses. Optionally reads every location back and compares it against a shadow copy.
- Holds the sequence counter cleared while loading. The top level muxes address and R_W between this block and AR using cpu_hold.

Parameters:
- ADDR_W, 4, RAM address width; memory depth = 2**ADDR_W.
- DATA_W, 8, RAM word width.
- VERIFY, 1, 1 = read-back compare after writing; 0 = skip verify.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- CLR  in  1  reset, synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
- base_addr  in  ADDR_W  first RAM address; captured on start.
- length  in  ADDR_W+1  byte count, captured on start; 0 means 2**ADDR_W.
- byte_valid  in  1  stream byte available.
- byte_in  in  DATA_W  stream byte.
- byte_ready  out  1  loader can accept a byte.
- address  out  ADDR_W  RAM address.
- R_W  out  1  1 = read, 0 = write (RAM convention).
- data_out  out  DATA_W  write data; top level drives Data_Bus = data_oe ? data_out : 'z.
- data_oe  out  1  bus drive enable.
- data_in  in  DATA_W  Data_Bus sampled for verify.
- cpu_hold  out  1  forces the sequence counter clear and gives RAM ownership to the loader.
- busy  out  1  load or verify in progress.
- done  out  1  level; load (and verify) succeeded.
- error  out  1  level; verify mismatch.
- error_addr  out  ADDR_W  first mismatching address.

Behaviour:
- Reset (CLR=1 at posedge, any state): state=IDLE.
  - Outputs: R_W=1, data_oe=0, data_out=0, address=0, byte_ready=0, cpu_hold=0, busy=0, done=0, error=0, error_addr=0.
  - CLR mid-load abandons the operation. RAM contents already written stay written; nothing else is rolled back.
- States: IDLE, WAIT_BYTE, WRITE, VADDR, VCMP, DONE, ERROR.
- IDLE/DONE/ERROR + start=1:
  - Capture base_addr into the pointer and length into the counter (0 -> 2**ADDR_W).
  - Clear done, error and error_addr; set busy=1 and cpu_hold=1; go to WAIT_BYTE.
- start while busy: ignored.
- WAIT_BYTE:
  - byte_ready=1.
  - On byte_valid & byte_ready: latch byte_in into data_out and into shadow[pointer], then go to WRITE.
  - No timeout; the loader waits indefinitely.
- WRITE (exactly 1 cycle):
  - R_W=0, data_oe=1, address=pointer; the RAM captures at the closing posedge.
  - Then pointer increments modulo 2**ADDR_W (wraps 15 -> 0) and the counter decrements.
  - If the counter reaches 0: go to VADDR with the pointer reset to base_addr if VERIFY=1, else go to DONE. Otherwise return to WAIT_BYTE.
- Throughput: 2 cycles per byte when byte_valid is held high.
- VADDR (1 cycle): R_W=1, data_oe=0, address=pointer.
- VCMP (1 cycle):
  - Address is held; sample data_in and compare with shadow[pointer].
  - Mismatch: error_addr=pointer, go to ERROR.
  - Match: advance pointer and counter as in WRITE. At counter 0 go to DONE, else go to VADDR.
- Verify cost: 2 cycles per byte.
- DONE: done=1, busy=0, cpu_hold=0, R_W=1, data_oe=0.
- ERROR: error=1, busy=0. cpu_hold stays 1 so the CPU does not run a corrupt image; it is released only by CLR or a new start.
- data_oe is high only in WRITE. R_W=0 is likewise only in WRITE. No bus contention in any other state.
- shadow is a 2**ADDR_W x DATA_W register array; it is not cleared by CLR (contents are don't-care until written).
- Length larger than memory is impossible (max 2**ADDR_W). A full-length load from a nonzero base wraps and covers every address once.

Test Plan:
- base=0, length=3, bytes 0x2A, 0x15, 0x80, valid held high:
  - Writes at addr 0,1,2 with R_W=0 one cycle each; byte_ready gaps of 1 cycle.
  - Verify reads all match; done=1 at 12 cycles after start, cpu_hold=0; RAM holds 2A/15/80.
- base=14, length=4, bytes 01..04: writes land at 14, 15, 0, 1 (wrap); done=1; address never exceeds 15.
- length=0, base=0, 16 bytes 0x00..0x0F: all 16 locations written and verified; done=1 after 64 cycles.
- Verify fault: force data_in=0xFF during the VCMP of addr 2 (expected 0x80):
  - error=1, error_addr=2, done=0, cpu_hold stays 1.
  - A new start clears error.
- Assert CLR during the second WRITE: next cycle IDLE, R_W=1, data_oe=0, busy=0, cpu_hold=0, done=0. A subsequent start succeeds.
- byte_valid toggling (1 every 3 cycles), plus start pulsed while busy:
  - Only handshaken bytes are written, in order.
  - The extra start has no effect (base/length unchanged).
  - data_oe is never high outside WRITE.
